uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser_if.sv | 25 ++
 rtl/uart_cmd_parser.sv | 189 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - UART byte stream, transmitter and PSRAM request signals of the command parser
interface uart_cmd_parser_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        tx_busy;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        req_stb;
    logic        req_we;
    logic [23:0] req_addr;
    logic [15:0] req_wdat;
    logic        psram_busy;
    logic [15:0] psram_rdat;

    modport master (
        input  rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
        output rx_read, tx_write, tx_data, req_stb, req_we, req_addr, req_wdat
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
        input  rx_read, tx_write, tx_data, req_stb, req_we, req_addr, req_wdat
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART command frame parser issuing PSRAM read/write requests
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_TICKS = 50000,
    parameter logic [7:0]  ACK_BYTE      = 8'hA5,
    parameter logic [7:0]  ERR_BYTE      = 8'hEE
) (
    input  logic                     clk_out,
    input  logic                     arst_n,
    input  logic                     tick_02us_i,
    uart_cmd_parser_if.master        bus,
    output logic [7:0]               err_count_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_RX_ADDR, S_RX_DATA, S_ISSUE, S_WAIT_ACK,
        S_WAIT_DONE, S_TX_HI, S_TX_LO, S_TX_ONE
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_TICKS - 1);

    state_e      state_q, state_d;
    logic        op_wr_q, op_wr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] wdat_q, wdat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [7:0]  one_q, one_d;
    logic [15:0] tmo_q, tmo_d;
    logic        lo_arm_q, lo_arm_d;
    logic [7:0]  err_q, err_d;

    logic        overrun, proto_err;
    logic        tx_write, req_stb, req_we;
    logic [7:0]  tx_data;

    always_ff @(posedge clk_out or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            op_wr_q  <= 1'b0;
            cnt_q    <= 2'd0;
            addr_q   <= 24'd0;
            wdat_q   <= 16'd0;
            rdat_q   <= 16'd0;
            one_q    <= 8'd0;
            tmo_q    <= 16'd0;
            lo_arm_q <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_wr_q  <= op_wr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            one_q    <= one_d;
            tmo_q    <= tmo_d;
            lo_arm_q <= lo_arm_d;
            err_q    <= err_d;
        end
    end

    // Any byte arriving after the frame is complete is dropped and counted.
    assign overrun = bus.rx_valid &&
                     (state_q inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_TX_HI, S_TX_LO, S_TX_ONE});

    always_comb begin
        state_d   = state_q;
        op_wr_d   = op_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rdat_d    = rdat_q;
        one_d     = one_q;
        tmo_d     = tmo_q;
        lo_arm_d  = lo_arm_q;
        proto_err = 1'b0;
        tx_write  = 1'b0;
        tx_data   = 8'd0;
        req_stb   = 1'b0;
        req_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == 8'h00 || bus.rx_data == 8'h01) begin
                        op_wr_d = bus.rx_data[0];
                        cnt_d   = 2'd0;
                        tmo_d   = 16'd0;
                        state_d = S_RX_ADDR;
                    end else begin
                        one_d     = ERR_BYTE;
                        proto_err = 1'b1;
                        state_d   = S_TX_ONE;
                    end
                end
            end
            S_RX_ADDR, S_RX_DATA: begin
                // A byte in the same cycle as the final tick still counts.
                if (bus.rx_valid) begin
                    tmo_d = 16'd0;
                    if (state_q == S_RX_ADDR) begin
                        addr_d = {addr_q[15:0], bus.rx_data};
                        if (cnt_q == 2'd2) begin
                            cnt_d   = 2'd0;
                            state_d = op_wr_q ? S_RX_DATA : S_ISSUE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else begin
                        wdat_d = {wdat_q[7:0], bus.rx_data};
                        if (cnt_q == 2'd1) begin
                            cnt_d   = 2'd0;
                            state_d = S_ISSUE;
                        end else begin
                            cnt_d = cnt_q + 2'd1;
                        end
                    end
                end else if (tick_02us_i) begin
                    if (tmo_q == TMO_LAST) begin
                        tmo_d     = 16'd0;
                        proto_err = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            S_ISSUE: begin
                req_stb = 1'b1;
                req_we  = op_wr_q;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!bus.psram_busy) begin
                    if (op_wr_q) begin
                        one_d   = ACK_BYTE;
                        state_d = S_TX_ONE;
                    end else begin
                        rdat_d  = bus.psram_rdat;
                        state_d = S_TX_HI;
                    end
                end
            end
            S_TX_HI: begin
                tx_data = rdat_q[15:8];
                if (!bus.tx_busy) begin
                    tx_write = 1'b1;
                    lo_arm_d = 1'b1;
                    state_d  = S_TX_LO;
                end
            end
            S_TX_LO: begin
                // The transmitter raises busy one cycle after a load.
                tx_data = rdat_q[7:0];
                if (lo_arm_q) begin
                    lo_arm_d = 1'b0;
                end else if (!bus.tx_busy) begin
                    tx_write = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_TX_ONE: begin
                tx_data = one_q;
                if (!bus.tx_busy) begin
                    tx_write = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_d = ((proto_err || overrun) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    assign bus.rx_read  = bus.rx_valid;
    assign bus.tx_write = tx_write;
    assign bus.tx_data  = tx_data;
    assign bus.req_stb  = req_stb;
    assign bus.req_we   = req_we;
    assign bus.req_addr = addr_q;
    assign bus.req_wdat = wdat_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    logic        clk_out = 1'b0;
    logic        arst_n = 1'b0;
    logic        tick_02us = 1'b0;
    logic [7:0]  err_count;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .TIMEOUT_TICKS (200),
        .ACK_BYTE      (8'hA5),
        .ERR_BYTE      (8'hEE)
    ) dut (
        .clk_out     (clk_out),
        .arst_n      (arst_n),
        .tick_02us_i (tick_02us),
        .bus         (bus),
        .err_count_o (err_count)
    );

    always #50 clk_out = ~clk_out;
    always @(negedge clk_out) tick_02us = ~tick_02us;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          viol = 0;
    int          stb_cnt = 0;
    logic        stb_we;
    logic [23:0] stb_addr;
    logic [15:0] stb_wdat;
    logic [7:0]  tx_q[$];
    int          tx_cnt = 0;
    int          ps_cnt = 0;
    int          ps_len = 3;
    logic        tx_busy_m = 1'b0;
    logic        tx_hold = 1'b0;
    logic        prev_txw = 1'b0;
    logic [15:0] rd_value = 16'h0000;

    assign bus.tx_busy    = tx_busy_m || tx_hold;
    assign bus.psram_rdat = bus.psram_busy ? 16'h0000 : rd_value;

    // Transmitter and PSRAM models plus protocol monitor.
    initial bus.psram_busy = 1'b0;
    always @(negedge clk_out) begin
        if (tx_cnt != 0) begin tx_busy_m = 1'b1; tx_cnt--; end
        else tx_busy_m = 1'b0;
        if (ps_cnt != 0) begin bus.psram_busy = 1'b1; ps_cnt--; end
        else bus.psram_busy = 1'b0;
        #1;
        if (bus.tx_write) begin
            tx_q.push_back(bus.tx_data);
            if (bus.tx_busy) viol++;
            if (prev_txw) viol++;
            tx_cnt = 4;
        end
        prev_txw = bus.tx_write;
        if (bus.rx_read !== bus.rx_valid) viol++;
        if (bus.req_stb) begin
            stb_cnt++;
            stb_we   = bus.req_we;
            stb_addr = bus.req_addr;
            stb_wdat = bus.req_wdat;
            ps_cnt   = ps_len;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] txb(input int i);
        return (tx_q.size() > i) ? {24'd0, tx_q[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_out);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk_out);
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_out);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tx_q.size() >= n) break;
            @(negedge clk_out);
            #2;
        end
        chk(tag, 32'(tx_q.size() >= n), 32'd1);
    endtask

    task automatic clear_obs();
        tx_q.delete();
        stb_cnt = 0;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        idle(3);
        #1;
        chk("rst_req_stb", 32'(bus.req_stb), 32'd0);
        chk("rst_req_we", 32'(bus.req_we), 32'd0);
        chk("rst_tx_write", 32'(bus.tx_write), 32'd0);
        chk("rst_req_addr", 32'(bus.req_addr), 32'd0);
        chk("rst_req_wdat", 32'(bus.req_wdat), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk_out);
        arst_n = 1'b1;
        idle(2);

        // Read frame
        rd_value = 16'hBEEF;
        send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        wait_tx("rd_wait", 2, 200);
        chk("rd_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("rd_req_we", 32'(stb_we), 32'd0);
        chk("rd_req_addr", 32'(stb_addr), 32'h123456);
        chk("rd_tx0", txb(0), 32'hBE);
        chk("rd_tx1", txb(1), 32'hEF);
        idle(8);
        chk("rd_addr_hold", 32'(bus.req_addr), 32'h123456);
        chk("rd_err", 32'(err_count), 32'd0);
        clear_obs();

        // Write frame
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h10); send_byte(8'hCA); send_byte(8'hFE);
        wait_tx("wr_wait", 1, 200);
        chk("wr_stb_cnt", 32'(stb_cnt), 32'd1);
        chk("wr_req_we", 32'(stb_we), 32'd1);
        chk("wr_req_addr", 32'(stb_addr), 32'h000010);
        chk("wr_req_wdat", 32'(stb_wdat), 32'hCAFE);
        chk("wr_tx0", txb(0), 32'hA5);
        idle(8);
        chk("wr_tx_count", 32'(tx_q.size()), 32'd1);
        clear_obs();

        // Invalid opcode
        send_byte(8'h7F);
        wait_tx("inv_wait", 1, 100);
        chk("inv_tx0", txb(0), 32'hEE);
        chk("inv_err", 32'(err_count), 32'd1);
        idle(8);
        chk("inv_stb_cnt", 32'(stb_cnt), 32'd0);
        clear_obs();

        // Inter-byte timeout (200 ticks = 400 cycles)
        send_byte(8'h00); send_byte(8'h12);
        idle(450);
        chk("tmo_err", 32'(err_count), 32'd2);
        chk("tmo_tx_count", 32'(tx_q.size()), 32'd0);
        chk("tmo_stb_cnt", 32'(stb_cnt), 32'd0);

        // Gaps just under the timeout must not expire
        rd_value = 16'h1234;
        send_byte(8'h00); idle(380);
        send_byte(8'hAB); idle(380);
        send_byte(8'hCD); idle(380);
        send_byte(8'hEF);
        wait_tx("gap_wait", 2, 200);
        chk("gap_req_addr", 32'(stb_addr), 32'hABCDEF);
        chk("gap_tx0", txb(0), 32'h12);
        chk("gap_tx1", txb(1), 32'h34);
        chk("gap_err", 32'(err_count), 32'd2);
        idle(8);
        clear_obs();

        // Overrun during WAIT_DONE
        ps_len   = 20;
        rd_value = 16'h1357;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        idle(4);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h99;
        #1;
        chk("ovr_rx_read", 32'(bus.rx_read), 32'd1);
        @(negedge clk_out);
        bus.rx_valid = 1'b0;
        #1;
        chk("ovr_err", 32'(err_count), 32'd3);
        wait_tx("ovr_wait", 2, 200);
        chk("ovr_tx0", txb(0), 32'h13);
        chk("ovr_tx1", txb(1), 32'h57);
        chk("ovr_stb_cnt", 32'(stb_cnt), 32'd1);
        idle(8);
        clear_obs();
        ps_len = 3;

        // Saturation: every invalid or overrun byte counts once
        for (int i = 0; i < 251; i++) send_byte(8'h80);
        #1;
        chk("sat_fe", 32'(err_count), 32'hFE);
        for (int i = 0; i < 49; i++) send_byte(8'h80);
        #1;
        chk("sat_ff", 32'(err_count), 32'hFF);
        idle(20);
        clear_obs();

        // Reset while TX_LO waits on a busy transmitter
        rd_value = 16'hABCD;
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_tx("rstlo_wait", 1, 200);
        @(negedge clk_out);
        tx_hold = 1'b1;
        @(negedge clk_out);
        arst_n = 1'b0;
        #1;
        chk("rstlo_tx_write", 32'(bus.tx_write), 32'd0);
        chk("rstlo_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rstlo_req_addr", 32'(bus.req_addr), 32'd0);
        chk("rstlo_req_stb", 32'(bus.req_stb), 32'd0);
        chk("rstlo_err", 32'(err_count), 32'd0);
        idle(2);
        arst_n  = 1'b1;
        tx_hold = 1'b0;
        idle(8);
        clear_obs();
        rd_value = 16'h0F0F;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        wait_tx("post_wait", 2, 200);
        chk("post_req_addr", 32'(stb_addr), 32'h000020);
        chk("post_tx0", txb(0), 32'h0F);
        chk("post_tx1", txb(1), 32'h0F);
        chk("post_err", 32'(err_count), 32'd0);
        idle(8);

        chk("protocol_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
